// File: rtl/fft_stream.sv
// fft_stream: streaming radix-2 DIF FFT/IFFT of length N = 2^N_LOG2.
// Real samples are loaded in arrival order and transformed in place, one
// butterfly per cycle. The bins are then streamed out in natural order with
// a valid/ready handshake.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   data            signed real input sample (DW bits)
//   data_valid      data holds a sample
//   in_ready        the block accepts a sample this cycle (IDLE/LOAD)
//   inverse         1 = IFFT (conjugate twiddles, unscaled), captured with x[0]
//   fft_re, fft_im  signed output bin components (OW bits, saturated)
//   fft_idx         bin index of the current output
//   fft_valid       output bin is valid
//   fft_ready       consumer accepts the current bin
//   done            one-cycle pulse when the last bin has been accepted
//   sat             some component of the current frame was saturated
module fft_stream #(
   parameter int N_LOG2 = 4,
   parameter int DW     = 16,
   parameter int OW     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     data,
   input  logic              data_valid,
   output logic              in_ready,
   input  logic              inverse,
   output logic [OW-1:0]     fft_re,
   output logic [OW-1:0]     fft_im,
   output logic [N_LOG2-1:0] fft_idx,
   output logic              fft_valid,
   input  logic              fft_ready,
   output logic              done,
   output logic              sat
);
   localparam int N   = 1 << N_LOG2;
   localparam int NBF = N / 2;
   localparam int BW  = N_LOG2 - 1;     // butterfly counter width
   localparam int IW  = DW + N_LOG2 + 9; // internal component width, 8 frac bits
   localparam int SW  = IW - 8;          // integer part after dropping fraction
   localparam int PW  = IW + 20;         // product / sum width
   localparam int TSH = 5 - N_LOG2;      // scale k onto the 32-point table

   localparam logic signed [SW-1:0] SMAX = SW'((64'sd1 <<< (OW-1)) - 64'sd1);
   localparam logic signed [SW-1:0] SMIN = SW'(-(64'sd1 <<< (OW-1)));

   typedef enum logic [1:0] {IDLE, LOAD, CAL, OUT} state_t;

   state_t            state;
   logic [N_LOG2-1:0] cnt;
   logic [2:0]        stg;
   logic [BW-1:0]     bf;
   logic              inv_r;
   logic              accept;

   logic signed [IW-1:0] mem_re [N];
   logic signed [IW-1:0] mem_im [N];

   // Q16 cosine of 2*pi*k/32 for k = 0..15; smaller N index it with stride.
   function automatic logic signed [17:0] cos32(input logic [3:0] k);
      case (k)
         4'd0:    cos32 = 18'sd65536;
         4'd1:    cos32 = 18'sd64277;
         4'd2:    cos32 = 18'sd60547;
         4'd3:    cos32 = 18'sd54491;
         4'd4:    cos32 = 18'sd46341;
         4'd5:    cos32 = 18'sd36410;
         4'd6:    cos32 = 18'sd25080;
         4'd7:    cos32 = 18'sd12785;
         4'd8:    cos32 = 18'sd0;
         4'd9:    cos32 = -18'sd12785;
         4'd10:   cos32 = -18'sd25080;
         4'd11:   cos32 = -18'sd36410;
         4'd12:   cos32 = -18'sd46341;
         4'd13:   cos32 = -18'sd54491;
         4'd14:   cos32 = -18'sd60547;
         default: cos32 = -18'sd64277;
      endcase
   endfunction

   // sin(2*pi*k/32) = cos(2*pi*|k-8|/32) for k in 0..15
   function automatic logic signed [17:0] sin32(input logic [3:0] k);
      sin32 = cos32((k >= 4'd8) ? (k - 4'd8) : (4'd8 - k));
   endfunction

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
      for (int i = 0; i < N_LOG2; i++) bitrev[i] = v[N_LOG2-1-i];
   endfunction

   // Floor-drop the fraction and clamp; MSB of the result flags saturation.
   function automatic logic [OW:0] sat_fn(input logic signed [IW-1:0] v);
      logic signed [SW-1:0] s;
      s = SW'(v >>> 8);
      if (s > SMAX)      sat_fn = {1'b1, 1'b0, {(OW-1){1'b1}}};
      else if (s < SMIN) sat_fn = {1'b1, 1'b1, {(OW-1){1'b0}}};
      else               sat_fn = {1'b0, OW'(s)};
   endfunction

   assign in_ready = (state == IDLE) || (state == LOAD);
   assign accept   = data_valid & in_ready;

   // Butterfly addressing: a is j with a 0 inserted at the span bit, b = a + span.
   logic [N_LOG2-1:0]    span, lo_mask, j_ext, a_idx, b_idx, tw_k;
   logic [3:0]           t32;
   logic signed [17:0]   w_cos, w_sin;
   logic signed [PW-1:0] wr, wi, dr, di, pr, pi;
   logic signed [IW-1:0] ar, ai, br, bi, sr, si, nr, ni;

   always_comb begin
      span    = N_LOG2'(1) << (3'(BW) - stg);
      lo_mask = span - N_LOG2'(1);
      j_ext   = N_LOG2'(bf);
      a_idx   = ((j_ext & ~lo_mask) << 1) | (j_ext & lo_mask);
      b_idx   = a_idx | span;
      tw_k    = (j_ext & lo_mask) << stg;
      t32     = 4'(5'(tw_k) << TSH);
      w_cos   = cos32(t32);
      w_sin   = sin32(t32);
      ar      = mem_re[a_idx];
      ai      = mem_im[a_idx];
      br      = mem_re[b_idx];
      bi      = mem_im[b_idx];
      // forward W = cos - j*sin, inverse uses the conjugate
      wr      = PW'(w_cos);
      wi      = inv_r ? PW'(w_sin) : -PW'(w_sin);
      dr      = PW'(ar) - PW'(br);
      di      = PW'(ai) - PW'(bi);
      pr      = dr * wr - di * wi + (PW'(1) <<< 15);
      pi      = dr * wi + di * wr + (PW'(1) <<< 15);
      sr      = ar + br;
      si      = ai + bi;
      nr      = IW'(pr >>> 16);
      ni      = IW'(pi >>> 16);
   end

   // Output fetch: next bin in natural order, read from bit-reversed slot.
   logic [N_LOG2-1:0] nxt_idx, rd_idx;
   logic [OW:0]       o_re, o_im;

   always_comb begin
      nxt_idx = fft_valid ? fft_idx + N_LOG2'(1) : '0;
      rd_idx  = bitrev(nxt_idx);
      o_re    = sat_fn(mem_re[rd_idx]);
      o_im    = sat_fn(mem_im[rd_idx]);
   end

   // Sample / working memory, no reset needed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) begin
            mem_re[cnt] <= IW'($signed(data)) <<< 8;
            mem_im[cnt] <= '0;
         end else if (state == CAL) begin
            mem_re[a_idx] <= sr;
            mem_im[a_idx] <= si;
            mem_re[b_idx] <= nr;
            mem_im[b_idx] <= ni;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         stg       <= '0;
         bf        <= '0;
         inv_r     <= 1'b0;
         fft_re    <= '0;
         fft_im    <= '0;
         fft_idx   <= '0;
         fft_valid <= 1'b0;
         done      <= 1'b0;
         sat       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               inv_r <= inverse;
               sat   <= 1'b0;
               cnt   <= N_LOG2'(1);
               state <= LOAD;
            end
            LOAD: if (accept) begin
               if (cnt == N_LOG2'(N-1)) begin
                  cnt   <= '0;
                  stg   <= '0;
                  bf    <= '0;
                  state <= CAL;
               end else begin
                  cnt <= cnt + N_LOG2'(1);
               end
            end
            CAL: begin
               if (bf == BW'(NBF-1)) begin
                  bf <= '0;
                  if (stg == 3'(N_LOG2-1)) begin
                     stg   <= '0;
                     state <= OUT;
                  end else begin
                     stg <= stg + 3'd1;
                  end
               end else begin
                  bf <= bf + BW'(1);
               end
            end
            OUT: begin
               // first OUT cycle fetches bin 0; afterwards advance on handshake
               if (!fft_valid || (fft_ready && fft_idx != N_LOG2'(N-1))) begin
                  fft_re    <= o_re[OW-1:0];
                  fft_im    <= o_im[OW-1:0];
                  fft_idx   <= nxt_idx;
                  fft_valid <= 1'b1;
                  if (o_re[OW] || o_im[OW]) sat <= 1'b1;
               end else if (fft_ready) begin
                  fft_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stream.sv
// tb_fft_stream: directed + randomized bench for fft_stream (N=16). A second
// instance with OW=8 shares all inputs and is only examined for saturation.
// Expected bins come from a direct floating-point DFT of the frame.
module tb_fft_stream;
   localparam int  N  = 16;
   localparam int  DW = 16;
   localparam real PI = 3.14159265358979;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data = '0;
   logic          data_valid = 1'b0;
   logic          inverse = 1'b0;
   logic          fft_ready = 1'b1;
   logic          in_ready, fft_valid, done, sat;
   logic [15:0]   fft_re, fft_im;
   logic [3:0]    fft_idx;
   logic          in_ready8, valid8, done8, sat8;
   logic [7:0]    re8, im8;
   logic [3:0]    idx8;

   fft_stream #(.N_LOG2(4), .DW(16), .OW(16)) dut (
      .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
      .in_ready(in_ready), .inverse(inverse), .fft_re(fft_re), .fft_im(fft_im),
      .fft_idx(fft_idx), .fft_valid(fft_valid), .fft_ready(fft_ready),
      .done(done), .sat(sat));

   fft_stream #(.N_LOG2(4), .DW(16), .OW(8)) dut8 (
      .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
      .in_ready(in_ready8), .inverse(inverse), .fft_re(re8), .fft_im(im8),
      .fft_idx(idx8), .fft_valid(valid8), .fft_ready(fft_ready),
      .done(done8), .sat(sat8));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;
   int x [N];
   bit inv_f;
   int last_acc, first_vld;
   int g_re [N], g_im [N], g8_re [N], g8_im [N], s_re [N], s_im [N];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input real exp, input real tol);
      compared++;
      assert (((real'(obs) - exp <= tol) && (exp - real'(obs) <= tol)) === 1'b1) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0.3f +/- %0.1f", tag, obs, exp, tol);
      end
   endtask

   function automatic real ref_re(input int k);
      real acc = 0.0;
      for (int n = 0; n < N; n++) acc += real'(x[n]) * $cos(2.0 * PI * real'(k * n) / real'(N));
      return acc;
   endfunction

   function automatic real ref_im(input int k);
      real acc = 0.0;
      for (int n = 0; n < N; n++) acc += real'(x[n]) * $sin(2.0 * PI * real'(k * n) / real'(N));
      return inv_f ? acc : -acc;
   endfunction

   // Feed x[start..N-1]; inverse carries inv_f only alongside x[0].
   task automatic send_frame(input int start, input bit chk_sat);
      for (int i = start; i < N; i++) begin
         int w;
         w = 0;
         while (!in_ready && w < 500) begin
            step();
            w++;
         end
         if (w >= 500) chk("in_ready_timeout", int'(in_ready), 1);
         data       = DW'(x[i]);
         inverse    = (i == 0) ? inv_f : ~inv_f;
         data_valid = 1'b1;
         step();
         if (i == 0 && chk_sat) chk("sat_cleared_on_x0", int'(sat8), 0);
      end
      data_valid = 1'b0;
      last_acc   = cyc;
   endtask

   // Drain one frame; rnd selects pseudo-random fft_ready.
   task automatic collect(input bit rnd);
      int nb, budget, early_done, p_re, p_im, p_idx;
      bit stalled, r;
      nb = 0; budget = 0; early_done = 0; stalled = 0;
      p_re = 0; p_im = 0; p_idx = 0;
      first_vld = -1;
      while (nb < N && budget < 2000) begin
         if (done) early_done++;
         if (stalled) begin
            chk("stall_valid", int'(fft_valid), 1);
            chk("stall_re", int'($signed(fft_re)), p_re);
            chk("stall_im", int'($signed(fft_im)), p_im);
            chk("stall_idx", int'(fft_idx), p_idx);
         end
         if (fft_valid) begin
            if (first_vld < 0) first_vld = cyc;
            chk("idx_order", int'(fft_idx), nb);
         end
         r = rnd ? 1'($urandom_range(1)) : 1'b1;
         fft_ready = r;
         if (fft_valid && r) begin
            g_re[nb]  = int'($signed(fft_re));
            g_im[nb]  = int'($signed(fft_im));
            g8_re[nb] = int'($signed(re8));
            g8_im[nb] = int'($signed(im8));
            nb++;
         end
         stalled = fft_valid && !r;
         p_re  = int'($signed(fft_re));
         p_im  = int'($signed(fft_im));
         p_idx = int'(fft_idx);
         step();
         budget++;
      end
      chk("frame_bins", nb, N);
      chk("early_done", early_done, 0);
      chk("done_pulse", int'(done), 1);
      chk("done_in_ready", int'(in_ready), 1);
      chk("done_valid_low", int'(fft_valid), 0);
      fft_ready = 1'b1;
      step();
      chk("done_one_cycle", int'(done), 0);
   endtask

   task automatic check_ref(input string tag, input real tol);
      for (int k = 0; k < N; k++) begin
         chk_near($sformatf("%s_bin%0d_re", tag, k), g_re[k], ref_re(k), tol);
         chk_near($sformatf("%s_bin%0d_im", tag, k), g_im[k], ref_im(k), tol);
      end
   endtask

   initial begin
      // reset state
      step();
      step();
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_valid", int'(fft_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sat", int'(sat), 0);
      chk("rst_re", int'(fft_re), 0);
      chk("rst_im", int'(fft_im), 0);
      chk("rst_idx", int'(fft_idx), 0);
      rst = 1'b0;

      // impulse: flat spectrum
      foreach (x[i]) x[i] = 0;
      x[0] = 100; inv_f = 0;
      send_frame(0, 0);
      collect(0);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("imp_re%0d", k), g_re[k], 100);
         chk($sformatf("imp_im%0d", k), g_im[k], 0);
      end
      chk("imp_latency", first_vld - last_acc, 33);

      // alternating +/-1000: all energy in bin 8
      foreach (x[i]) x[i] = (i % 2 == 0) ? 1000 : -1000;
      send_frame(0, 0);
      collect(0);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("alt_re%0d", k), g_re[k], (k == 8) ? 16000 : 0);
         chk($sformatf("alt_im%0d", k), g_im[k], 0);
      end
      chk("alt_latency", first_vld - last_acc, 33);

      // DC 100: OW=8 instance saturates bin 0
      foreach (x[i]) x[i] = 100;
      send_frame(0, 0);
      collect(0);
      chk("dc8_bin0", g8_re[0], 127);
      chk("dc16_bin0", g_re[0], 1600);
      for (int k = 0; k < N; k++) begin
         if (k > 0) chk($sformatf("dc8_re%0d", k), g8_re[k], 0);
         chk($sformatf("dc8_im%0d", k), g8_im[k], 0);
      end
      chk("dc8_sat", int'(sat8), 1);
      chk("dc16_sat", int'(sat), 0);
      repeat (3) step();
      chk("dc8_sat_held", int'(sat8), 1);

      // x[1]=1000 forward, then inverse frame back to back
      foreach (x[i]) x[i] = 0;
      x[1] = 1000; inv_f = 0;
      send_frame(0, 1);
      data = DW'(x[0]); inverse = 1'b1; data_valid = 1'b1;
      collect(0);
      chk("fwd_bin4_re", g_re[4], 0);
      chk("fwd_bin4_im", g_im[4], -1000);
      check_ref("fwd", 1.0);
      inv_f = 1;
      send_frame(1, 0);
      collect(0);
      chk("inv_bin4_re", g_re[4], 0);
      chk("inv_bin4_im", g_im[4], 1000);
      check_ref("inv", 1.0);
      chk("b2b_latency", first_vld - last_acc, 33);

      // random frames
      repeat (3) begin
         foreach (x[i]) x[i] = int'($urandom_range(4000)) - 2000;
         inv_f = 1'($urandom_range(1));
         send_frame(0, 0);
         collect(0);
         check_ref("rnd", 2.0);
      end
      s_re = g_re;
      s_im = g_im;

      // same frame again with random backpressure
      send_frame(0, 0);
      collect(1);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("stall_seq_re%0d", k), g_re[k], s_re[k]);
         chk($sformatf("stall_seq_im%0d", k), g_im[k], s_im[k]);
      end

      // reset in the middle of CAL abandons the frame
      foreach (x[i]) x[i] = int'($urandom_range(4000)) - 2000;
      inv_f = 0;
      send_frame(0, 0);
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_in_ready", int'(in_ready), 1);
      repeat (80) begin
         chk("abort_quiet", int'({fft_valid, done}), 0);
         step();
      end
      foreach (x[i]) x[i] = 0;
      x[0] = 100;
      send_frame(0, 0);
      collect(0);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("post_abort_re%0d", k), g_re[k], 100);
         chk($sformatf("post_abort_im%0d", k), g_im[k], 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
